// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;
  localparam int CNT_W          = 4;
  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DMA = 2'd2
  } state_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of consecutive DMA arbitration losses
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic starved_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign starved_o = cnt_q >= CNT_W'(STARVE_MAX);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU MEM stage (priority) and a DMA port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_byte,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_done,
  output logic        dma_gnt,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic        mem_eightbit,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata16,
  input  logic [7:0]  mem_rdata8
);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             en_q, en_d, rw_q, rw_d, b8_q, b8_d;
  logic [15:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [15:0]      cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic             cpu_done_q, cpu_done_d, dma_done_q, dma_done_d, gnt_q;
  logic             eff_cpu, eff_dma, dma_win, cpu_win, starved, inc, clr, last;
  logic [15:0]      rd;

  // A requester whose done is high is still holding req from the finished access
  assign eff_cpu = cpu_req & ~cpu_done_q;
  assign eff_dma = dma_req & ~dma_done_q;
  assign dma_win = eff_dma & (~eff_cpu | starved);
  assign cpu_win = eff_cpu & ~dma_win;
  assign inc     = (state_q == IDLE) & eff_dma & cpu_win;
  assign clr     = (state_q == IDLE) & dma_win;
  assign last    = (state_q != IDLE) && (lat_q == '0);
  assign rd      = b8_q ? {8'h00, mem_rdata8} : mem_rdata16;

  starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk_i    (clk),
    .rst_i    (reset),
    .inc_i    (inc),
    .clr_i    (clr),
    .starved_o(starved)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    en_d        = en_q;
    rw_d        = rw_q;
    b8_d        = b8_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = (last && state_q == BUSY_CPU && !rw_q) ? rd : cpu_rdata_q;
    dma_rdata_d = (last && state_q == BUSY_DMA && !rw_q) ? rd : dma_rdata_q;
    cpu_done_d  = last && state_q == BUSY_CPU;
    dma_done_d  = last && state_q == BUSY_DMA;
    if (state_q == IDLE) begin
      if (dma_win || cpu_win) begin
        state_d = dma_win ? BUSY_DMA : BUSY_CPU;
        en_d    = 1'b1;
        lat_d   = LAT_INIT;
        rw_d    = dma_win ? dma_we    : cpu_we;
        b8_d    = dma_win ? dma_byte  : cpu_byte;
        addr_d  = dma_win ? dma_addr  : cpu_addr;
        wdata_d = dma_win ? dma_wdata : cpu_wdata;
      end
    end else if (last) begin
      state_d = IDLE;
      en_d    = 1'b0;
      rw_d    = 1'b0;
      b8_d    = 1'b0;
    end else begin
      lat_d = lat_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      b8_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      gnt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      b8_q        <= b8_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      gnt_q       <= state_d == BUSY_DMA;
    end
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_done     = cpu_done_q;
  assign cpu_stall    = cpu_req & ~cpu_done_q;
  assign dma_rdata    = dma_rdata_q;
  assign dma_done     = dma_done_q;
  assign dma_gnt      = gnt_q;
  assign mem_enable   = en_q;
  assign mem_rw       = rw_q;
  assign mem_eightbit = b8_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
endmodule
